// File: rtl/mips_datapath_memory_arbiter.sv
// Arbiter sharing the memory datapath between fetch (I) and data (D) requesters; optional
// MIPS_DATAPATH_MEMORY_ARBITER_ALIGNCHECK_EN adds i_err/d_err. ByteEnable: 0 None,1 Byte,2 Half,3 Word.
module mips_datapath_memory_arbiter #(
  parameter int unsigned ADDR_L     = 64,
  parameter int unsigned ADDR_W     = $clog2(ADDR_L),
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_rst,
  input  logic              i_req,
  input  logic [ADDR_W+1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W+1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic              d_control_we,
  input  logic [1:0]        d_control_be,
  input  logic              d_control_sx,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_control_we,
  output logic [1:0]        mem_control_be,
  output logic              mem_control_sx,
  input  logic [31:0]       mem_out
`ifdef MIPS_DATAPATH_MEMORY_ARBITER_ALIGNCHECK_EN
  ,
  output logic              i_err,
  output logic              d_err
`endif
);

  localparam int unsigned   SW        = $clog2(STARVE_MAX) + 1;
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);
  localparam logic [1:0]    BeNone    = 2'd0;
  localparam logic [1:0]    BeWord    = 2'd3;

  logic [SW-1:0]      r_starve;
  logic [MEM_LAT-1:0] r_vld;
  logic [MEM_LAT-1:0] r_own;  // 1 = D owns the in-flight read
  logic               w_i_gnt;
  logic               w_d_gnt;
  logic               w_i_mis;
  logic               w_d_mis;
  logic               w_issue;

`ifdef MIPS_DATAPATH_MEMORY_ARBITER_ALIGNCHECK_EN
  localparam logic [1:0] BeHalf = 2'd2;

  logic r_i_err;
  logic r_d_err;

  assign w_i_mis = (i_addr[1:0] != 2'b00);
  assign w_d_mis = ((d_control_be == BeHalf) && d_addr[0]) ||
                   ((d_control_be == BeWord) && (d_addr[1:0] != 2'b00));

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_rst) begin
      r_i_err <= 1'b0;
      r_d_err <= 1'b0;
    end else begin
      r_i_err <= w_i_gnt & w_i_mis;
      r_d_err <= w_d_gnt & w_d_mis;
    end
  end

  assign i_err = r_i_err & ~ctrl_rst;
  assign d_err = r_d_err & ~ctrl_rst;
`else
  assign w_i_mis = 1'b0;
  assign w_d_mis = 1'b0;
`endif

  // D has priority until I has watched STARVE_MAX consecutive D grants.
  assign w_i_gnt = ~ctrl_rst & i_req & (~d_req | (r_starve == StarveMax));
  assign w_d_gnt = ~ctrl_rst & d_req & ~w_i_gnt;
  assign i_gnt   = w_i_gnt;
  assign d_gnt   = w_d_gnt;

  assign w_issue = (w_i_gnt & ~w_i_mis) |
                   (w_d_gnt & ~w_d_mis & ~d_control_we & (d_control_be != BeNone));

  always_comb begin
    mem_addr       = '0;
    mem_data       = '0;
    mem_control_we = 1'b0;
    mem_control_be = BeNone;
    mem_control_sx = 1'b0;
    if (w_i_gnt) begin
      mem_addr       = i_addr;
      mem_control_be = w_i_mis ? BeNone : BeWord;
      mem_control_sx = 1'b1;
    end else if (w_d_gnt) begin
      mem_addr       = d_addr;
      mem_data       = d_wdata;
      mem_control_we = d_control_we & ~w_d_mis;
      mem_control_be = w_d_mis ? BeNone : d_control_be;
      mem_control_sx = d_control_sx;
    end
  end

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_rst) begin
      r_starve <= '0;
      r_vld    <= '0;
      r_own    <= '0;
    end else begin
      if (w_i_gnt || !i_req) begin
        r_starve <= '0;
      end else if (w_d_gnt && (r_starve != StarveMax)) begin
        r_starve <= r_starve + SW'(1);
      end
      r_vld[0] <= w_issue;
      r_own[0] <= w_d_gnt;
      for (int k = 1; k < MEM_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_own[k] <= r_own[k-1];
      end
    end
  end

  assign i_rvalid = ~ctrl_rst & r_vld[MEM_LAT-1] & ~r_own[MEM_LAT-1];
  assign d_rvalid = ~ctrl_rst & r_vld[MEM_LAT-1] & r_own[MEM_LAT-1];
  assign i_rdata  = i_rvalid ? mem_out : 32'h0;
  assign d_rdata  = d_rvalid ? mem_out : 32'h0;

endmodule

// File: doc/mips_datapath_memory_arbiter.md
Name: mips_datapath_memory_arbiter

Overview:
- Shares the single memory datapath (byte-addressed BAM plus byte-enable/extend logic) between the instruction-fetch requester (I) and the data requester (D).
- Per cycle it grants at most one requester and drives the datapath's address, write data and memory control bundle.
- It tracks in-flight reads through a MEM_LAT-deep pipeline and returns each read word to its owner.
- Sits between the fetch/memory pipeline stages and mips_datapath_memory_datapath.

Parameters:
ADDR_L, 64, memory depth in 32-bit words (passed through to the datapath)
ADDR_W, Util_Math_log2(ADDR_L), word-address width; byte address is ADDR_W+2 bits
MEM_LAT, 1, cycles from issue to read data valid on mem_out (1..4)
STARVE_MAX, 4, consecutive D grants tolerated while I is waiting

Ports:
ctrl  input  Data_Control_Control_T  clock (rising edge) and reset; reset is synchronous and active-high
i_req  input  1  fetch request (read-only, word)
i_addr  input  ADDR_W+2  fetch byte address
i_gnt  output  1  fetch accepted this cycle (combinational)
i_rvalid  output  1  fetch read data valid
i_rdata  output  32  fetch read word
d_req  input  1  data request
d_addr  input  ADDR_W+2  data byte address
d_wdata  input  32  store data
d_control  input  Mips_Control_Signal_Memory_Control_T  data-side WriteEnable/ByteEnable/ByteExtend
d_gnt  output  1  data accepted this cycle (combinational)
d_rvalid  output  1  data read data valid (loads only)
d_rdata  output  32  data read word, already sized/extended
mem_addr  output  ADDR_W+2  to datapath addr
mem_data  output  32  to datapath data
mem_control  output  Mips_Control_Signal_Memory_Control_T  to datapath control
mem_out  input  32  from datapath out

Behaviour:
- Handshake: a request is accepted in any cycle where req & gnt. The requester holds req/addr/data until that cycle. At most one gnt is high per cycle. gnt never asserts without req.
- Arbitration (combinational on registered starve_cnt):
  - Only one requesting: it wins.
  - Both requesting: D wins unless starve_cnt == STARVE_MAX, in which case I wins.
- starve_cnt (registered, width log2(STARVE_MAX)+1):
  - Clears when i_gnt, or when i_req is low.
  - Otherwise increments on each d_gnt while i_req is high; saturates at STARVE_MAX.
- Datapath drive:
  - I granted: mem_addr=i_addr, mem_data=0, mem_control = WriteEnable off, ByteEnable Word, ByteExtend Signed.
  - D granted: mem_addr=d_addr, mem_data=d_wdata, mem_control=d_control.
  - No grant: mem_addr=0, mem_data=0, mem_control = WriteEnable off, ByteEnable None. The datapath must see no write.
- Issue pipeline: MEM_LAT-stage shift register of {valid, owner}.
  - valid = granted read: I always, or D with WriteEnable off and ByteEnable != None.
  - Stores and None accesses insert a bubble.
- At stage MEM_LAT: valid & owner==I pulses i_rvalid with i_rdata=mem_out; owner==D pulses d_rvalid with d_rdata=mem_out.
  - i_rvalid and d_rvalid are never high together.
  - rdata outputs read 0 when the matching rvalid is low.
- Throughput: one grant per cycle, back-to-back. Responses return in issue order at exactly MEM_LAT cycles after issue.
- Reset (synchronous, may occur mid-operation): pipeline valids clear, starve_cnt=0.
  - All outputs are 0 in the reset cycle: gnts, rvalids, rdata, mem_addr, mem_data, mem_control (ByteEnable None, write off).
  - In-flight reads are dropped; no rvalid pulses in the MEM_LAT cycles after reset unless new issues occur.
- Simultaneous req rise with reset: no grant.

Optional Feature:
MIPS_DATAPATH_MEMORY_ARBITER_ALIGNCHECK_EN
- Defined:
  - Adds output d_err (1 bit) and i_err (1 bit), both registered.
  - A misaligned access is: Half with addr[0]!=0, Word with addr[1:0]!=0, or an I request with i_addr[1:0]!=0.
  - A misaligned access is still granted, so the requester is released, but is issued to the datapath as ByteEnable None with write off. No response enters the pipeline.
  - The matching err pulses one cycle after the grant. starve_cnt updates as normal.
- Undefined: no err ports; addresses pass through unchecked.

Test Plan:
- Reset, then i_req=1, i_addr=0x10, memory word 0x11223344: i_gnt same cycle; i_rvalid=1 and i_rdata=0x11223344 exactly 1 cycle later (MEM_LAT=1).
- D store (Word, addr 0x08, data 0xDEADBEEF), then D load Byte Signed at 0x08 back-to-back: two consecutive d_gnt; single d_rvalid with d_rdata=0xFFFFFFEF; no rvalid for the store.
- i_req and d_req both held high (D loads) for 10 cycles with STARVE_MAX=4: grant sequence D,D,D,D,I,D,D,D,D,I.
- MEM_LAT=3, alternating I/D reads every cycle: rvalids return owner-correct, in order, 3 cycles after each grant, never both high.
- Reset asserted one cycle after a D load grant (MEM_LAT=2): no d_rvalid afterwards; all outputs 0 during reset; mem_control ByteEnable None.
- ALIGNCHECK_EN defined, D Word load at 0x06: d_gnt=1, mem_control ByteEnable None, d_err=1 next cycle, no d_rvalid.
